// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - state type and sizing helpers shared by the parametrised FIR filter
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOADC,
        CHECK,
        SHIFT,
        MAC,
        OUT,
        EIDLE
    } fir_state_t;

    // Unsigned Q1.(data_w-1): the coefficient value that represents 1.0
    function automatic int q_one(input int data_w);
        return 1 << (data_w - 1);
    endfunction

    // Wide enough that NUM_TAPS products of up to ~2.0 * full-scale never overflow, plus sign
    function automatic int acc_w(input int data_w, input int num_taps);
        return data_w + $clog2(num_taps) + 2;
    endfunction

endpackage

// File: rtl/fir_filter_param_if.sv
// rtl/fir_filter_param_if.sv - sample/coefficient request and result bundle of the FIR filter
interface fir_filter_param_if #(
    parameter int DATA_W = 16
);

    logic [DATA_W-1:0] sample_data;
    logic [DATA_W-1:0] fir_coefficient;
    logic              data_ready;
    logic              load_coeff;
    logic              modwait;
    logic [DATA_W-1:0] fir_out;
    logic              err;
    logic              coeffs_valid;
    logic              count_hit;

    modport master (
        output sample_data,
        output fir_coefficient,
        output data_ready,
        output load_coeff,
        input  modwait,
        input  fir_out,
        input  err,
        input  coeffs_valid,
        input  count_hit
    );

    modport slave (
        input  sample_data,
        input  fir_coefficient,
        input  data_ready,
        input  load_coeff,
        output modwait,
        output fir_out,
        output err,
        output coeffs_valid,
        output count_hit
    );

endinterface

// File: rtl/fir_coeff_bank.sv
// rtl/fir_coeff_bank.sv - coefficient registers with wrapping write index and load_coeff edge detect
module fir_coeff_bank #(
    parameter int NUM_TAPS = 4,
    parameter int DATA_W   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_coeff,
    input  logic                        load_en,
    input  logic [DATA_W-1:0]           coeff_in,
    input  logic [$clog2(NUM_TAPS)-1:0] rd_idx,
    output logic                        load_edge,
    output logic [DATA_W-1:0]           rd_coeff,
    output logic                        coeffs_valid
);

    localparam int IDX_W = $clog2(NUM_TAPS);

    logic              load_prev;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] coeff [NUM_TAPS];

    // load_prev tracks every cycle, so an edge that lands while busy is consumed, not queued
    assign load_edge = load_coeff & ~load_prev;
    assign rd_coeff  = coeff[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            load_prev    <= 1'b0;
            idx          <= '0;
            coeffs_valid <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                coeff[k] <= '0;
            end
        end else begin
            load_prev <= load_coeff;
            if (load_en) begin
                coeff[idx] <= coeff_in;
                if (idx == IDX_W'(NUM_TAPS - 1)) begin
                    idx          <= '0;
                    coeffs_valid <= 1'b1;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fir_filter_param.sv
// rtl/fir_filter_param.sv - parametrised FIR filter, one multiply-accumulate per cycle behind a modwait handshake
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int                  NUM_TAPS     = 4,
    parameter int                  DATA_W       = 16,
    parameter logic [NUM_TAPS-1:0] SIGN_MASK    = 4'b1010,
    parameter int                  SAT_MODE     = 1,
    parameter int                  COUNT_TARGET = 1000
) (
    input logic               clk,
    input logic               reset,
    fir_filter_param_if.slave bus
);

    localparam int IDX_W  = $clog2(NUM_TAPS);
    localparam int ACC_W  = acc_w(DATA_W, NUM_TAPS);
    localparam int FRAC_W = DATA_W - 1;
    localparam int CNT_W  = $clog2(COUNT_TARGET) + 1;
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W - DATA_W){1'b0}}, {DATA_W{1'b1}}};

    fir_state_t              state;
    logic [DATA_W-1:0]       dline [NUM_TAPS];
    logic [IDX_W-1:0]        tap;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        sample_cnt;
    logic                    modwait_q;
    logic [DATA_W-1:0]       fir_out_q;
    logic                    err_q;
    logic                    count_hit_q;

    logic                    load_edge;
    logic [DATA_W-1:0]       tap_coeff;
    logic                    coeffs_valid;
    logic [2*DATA_W-1:0]     full_prod;
    logic signed [ACC_W-1:0] prod;

    fir_coeff_bank #(
        .NUM_TAPS (NUM_TAPS),
        .DATA_W   (DATA_W)
    ) u_coeff_bank (
        .clk          (clk),
        .reset        (reset),
        .load_coeff   (bus.load_coeff),
        .load_en      (state == LOADC),
        .coeff_in     (bus.fir_coefficient),
        .rd_idx       (tap),
        .load_edge    (load_edge),
        .rd_coeff     (tap_coeff),
        .coeffs_valid (coeffs_valid)
    );

    // Drop the fractional bits of the Q1.(DATA_W-1) product; the result is always non-negative
    assign full_prod = dline[tap] * tap_coeff;
    assign prod      = ACC_W'(full_prod >> FRAC_W);

    assign bus.modwait      = modwait_q;
    assign bus.fir_out      = fir_out_q;
    assign bus.err          = err_q;
    assign bus.coeffs_valid = coeffs_valid;
    assign bus.count_hit    = count_hit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            modwait_q   <= 1'b0;
            fir_out_q   <= '0;
            err_q       <= 1'b0;
            count_hit_q <= 1'b0;
            tap         <= '0;
            acc         <= '0;
            sample_cnt  <= '0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                dline[k] <= '0;
            end
        end else begin
            count_hit_q <= 1'b0;
            case (state)
                IDLE, EIDLE: begin
                    if (load_edge) begin
                        state     <= LOADC;
                        modwait_q <= 1'b1;
                    end else if (bus.data_ready) begin
                        state     <= CHECK;
                        modwait_q <= 1'b1;
                    end
                end
                LOADC: begin
                    state     <= IDLE;
                    modwait_q <= 1'b0;
                end
                CHECK: begin
                    // A request that vanished after one cycle is treated as a glitch
                    if (bus.data_ready) begin
                        state <= SHIFT;
                    end else begin
                        state     <= EIDLE;
                        modwait_q <= 1'b0;
                        err_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    for (int k = NUM_TAPS - 1; k > 0; k--) begin
                        dline[k] <= dline[k-1];
                    end
                    dline[0] <= bus.sample_data;
                    acc      <= '0;
                    tap      <= '0;
                    state    <= MAC;
                end
                MAC: begin
                    acc <= SIGN_MASK[tap] ? acc - prod : acc + prod;
                    if (tap == IDX_W'(NUM_TAPS - 1)) begin
                        state <= OUT;
                    end else begin
                        tap <= tap + IDX_W'(1);
                    end
                end
                OUT: begin
                    if (acc[ACC_W-1]) begin
                        err_q     <= 1'b1;
                        fir_out_q <= (SAT_MODE != 0) ? '0 : acc[DATA_W-1:0];
                    end else if (acc > OUT_MAX) begin
                        err_q     <= 1'b1;
                        fir_out_q <= (SAT_MODE != 0) ? {DATA_W{1'b1}} : acc[DATA_W-1:0];
                    end else begin
                        err_q     <= 1'b0;
                        fir_out_q <= acc[DATA_W-1:0];
                    end
                    if (sample_cnt == CNT_W'(COUNT_TARGET - 1)) begin
                        sample_cnt  <= '0;
                        count_hit_q <= 1'b1;
                    end else begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                    end
                    state     <= IDLE;
                    modwait_q <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    modwait_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_param.sv
// tb/tb_fir_filter_param.sv - saturating and wrapping FIR instances driven in lockstep against a reference model
module tb_fir_filter_param;
    import fir_pkg::*;

    localparam int NT = 4;
    localparam int DW = 16;
    localparam logic [NT-1:0] SMASK = 4'b1010;
    localparam int TARGET = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [DW-1:0] sample_data = '0;
    logic [DW-1:0] fir_coefficient = '0;
    logic data_ready = 1'b0;
    logic load_coeff = 1'b0;

    always #5 clk = ~clk;

    fir_filter_param_if #(.DATA_W(DW)) bus_s ();
    fir_filter_param_if #(.DATA_W(DW)) bus_w ();

    assign bus_s.sample_data     = sample_data;
    assign bus_s.fir_coefficient = fir_coefficient;
    assign bus_s.data_ready      = data_ready;
    assign bus_s.load_coeff      = load_coeff;
    assign bus_w.sample_data     = sample_data;
    assign bus_w.fir_coefficient = fir_coefficient;
    assign bus_w.data_ready      = data_ready;
    assign bus_w.load_coeff      = load_coeff;

    fir_filter_param #(
        .NUM_TAPS(NT), .DATA_W(DW), .SIGN_MASK(SMASK), .SAT_MODE(1), .COUNT_TARGET(TARGET)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    fir_filter_param #(
        .NUM_TAPS(NT), .DATA_W(DW), .SIGN_MASK(SMASK), .SAT_MODE(0), .COUNT_TARGET(TARGET)
    ) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w)
    );

    int n_vec = 0;
    int n_bad = 0;

    longint hist[$];
    int     m_cf[NT];
    int     m_idx;
    bit     m_valid;
    bit     m_err;
    int     m_out_s;
    int     m_out_w;
    int     m_done;
    bit     m_hit;

    typedef struct {
        int sample;
        int out_s;
        int out_w;
        bit err;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hist = '{0, 0, 0, 0};
        for (int i = 0; i < NT; i++) m_cf[i] = 0;
        m_idx = 0;
        m_valid = 0;
        m_err = 0;
        m_out_s = 0;
        m_out_w = 0;
        m_done = 0;
        m_hit = 0;
    endfunction

    function automatic void model_load(input int c);
        m_cf[m_idx] = c;
        m_idx = (m_idx + 1) % NT;
        if (m_idx == 0) m_valid = 1;
    endfunction

    // Filter output from the newest NT samples, each weighted by a Q1.15 coefficient
    function automatic void model_sample(input int s);
        longint a = 0;
        longint p;
        hist.push_front(longint'(s));
        void'(hist.pop_back());
        for (int i = 0; i < NT; i++) begin
            p = (hist[i] * m_cf[i]) / q_one(DW);
            a = SMASK[i] ? a - p : a + p;
        end
        if (a < 0) begin
            m_err = 1;
            m_out_s = 0;
            m_out_w = int'(a & 65535);
        end else if (a > 65535) begin
            m_err = 1;
            m_out_s = 65535;
            m_out_w = int'(a & 65535);
        end else begin
            m_err = 0;
            m_out_s = int'(a);
            m_out_w = int'(a);
        end
        m_done++;
        m_hit = (m_done % TARGET) == 0;
    endfunction

    task automatic do_load(input int c);
        fir_coefficient = DW'(c);
        load_coeff = 1'b1;
        @(posedge clk); #1;
        chk("load_modwait_hi", bus_s.modwait, 1);
        load_coeff = 1'b0;
        @(posedge clk); #1;
        chk("load_modwait_lo", bus_s.modwait, 0);
        model_load(c);
        chk("coeffs_valid", bus_s.coeffs_valid, m_valid);
    endtask

    task automatic do_sample(input int s, input int hold, input bit poke_load);
        int hi;
        int guard;
        sample_data = DW'(s);
        data_ready = 1'b1;
        @(posedge clk); #1;
        hi = bus_s.modwait ? 1 : 0;
        chk("modwait_rise", bus_s.modwait, 1);
        for (int k = 1; k < hold; k++) begin
            @(posedge clk); #1;
            if (bus_s.modwait) hi++;
        end
        data_ready = 1'b0;
        guard = 0;
        while (bus_s.modwait && guard < 30) begin
            if (poke_load && hi == 4) begin
                fir_coefficient = 16'h1234;
                load_coeff = 1'b1;
            end else begin
                load_coeff = 1'b0;
            end
            @(posedge clk); #1;
            guard++;
            if (bus_s.modwait) hi++;
        end
        load_coeff = 1'b0;
        chk("modwait_len", hi, NT + 3);
        model_sample(s);
        chk("fir_out_sat", bus_s.fir_out, m_out_s);
        chk("fir_out_wrap", bus_w.fir_out, m_out_w);
        chk("err_sat", bus_s.err, m_err);
        chk("err_wrap", bus_w.err, m_err);
        chk("count_hit_s", bus_s.count_hit, m_hit);
        chk("count_hit_w", bus_w.count_hit, m_hit);
        chk("coeffs_valid_s", bus_s.coeffs_valid, m_valid);
        @(posedge clk); #1;
        chk("count_hit_drop", bus_s.count_hit, 0);
    endtask

    initial begin
        int c;
        model_reset();
        tbl[0] = '{sample: 100, out_s: 50, out_w: 50,    err: 0};
        tbl[1] = '{sample: 100, out_s: 0,  out_w: 65486, err: 1};
        tbl[2] = '{sample: 100, out_s: 50, out_w: 50,    err: 0};
        tbl[3] = '{sample: 100, out_s: 0,  out_w: 0,     err: 0};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_modwait", bus_s.modwait, 0);
        chk("rst_fir_out", bus_s.fir_out, 0);
        chk("rst_err", bus_s.err, 0);
        chk("rst_coeffs_valid", bus_s.coeffs_valid, 0);
        chk("rst_count_hit", bus_s.count_hit, 0);

        do_load(32'h4000);
        do_load(32'h8000);
        do_load(32'h8000);
        do_load(32'h4000);

        for (int i = 0; i < 4; i++) begin
            do_sample(tbl[i].sample, 2, 1'b0);
            chk("tbl_fir_out_sat", bus_s.fir_out, tbl[i].out_s);
            chk("tbl_fir_out_wrap", bus_w.fir_out, tbl[i].out_w);
            chk("tbl_err", bus_s.err, tbl[i].err);
        end

        // Single-cycle data_ready: discarded, err raised, output held
        data_ready = 1'b1;
        @(posedge clk); #1;
        data_ready = 1'b0;
        @(posedge clk); #1;
        m_err = 1;
        chk("short_modwait", bus_s.modwait, 0);
        chk("short_err", bus_s.err, 1);
        chk("short_fir_out", bus_s.fir_out, m_out_s);
        do_sample(200, 3, 1'b0);

        do_sample(1000, 2, 1'b0);
        do_sample(1000, 2, 1'b0);
        do_sample(0, 2, 1'b1);
        do_sample(300, 2, 1'b0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                c = (i % 2 == 0) ? int'($urandom_range(0, 16'h8000)) : int'($urandom_range(0, 16'hFFFF));
                do_load(c);
            end else begin
                do_sample(int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(2, 3)), 1'b0);
            end
        end

        // Reset in the middle of the MAC phase
        sample_data = 16'd100;
        data_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        data_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk("mid_rst_modwait", bus_s.modwait, 0);
        chk("mid_rst_fir_out", bus_s.fir_out, 0);
        chk("mid_rst_coeffs_valid", bus_s.coeffs_valid, 0);
        chk("mid_rst_err", bus_s.err, 0);
        do_sample(100, 2, 1'b0);
        chk("post_rst_fir_out", bus_s.fir_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
